bin_to_bcd_stream: RTL and testbench

Parametrised sequential binary-to-BCD converter (shift/add-3, one bit per clock) with valid/ready handshakes on input and output. Adds an optional two's-complement signed mode, a sticky overflow flag when DIGITS is too small, and a leading-zero blanking mask for display drivers. It sits between arithmetic datapaths and the 7-segment/display multiplexing logic.

---
 rtl/bin_to_bcd_stream.sv | 114 +++++++++++
 tb/tb_bin_to_bcd_stream.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_stream.sv
// Sequential binary-to-BCD converter (shift/add-3, one bit per clock) with
// valid/ready handshakes, optional two's-complement input, overflow and leading-zero mask.
//
// state   | meaning
// IDLE    | waiting for an input; in_ready high
// CONVERT | shifting one magnitude bit per clock into the digit accumulator
// HOLD    | result presented with out_valid until out_ready
module bin_to_bcd_stream #(
    parameter int IN_WIDTH  = 16,
    parameter int DIGITS    = 5,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   bin_in,
    input  logic                  signed_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank_mask,
    output logic                  busy
);

    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(IN_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;

    state_t                 state;
    logic [DW-1:0]          digits;
    logic [IN_WIDTH-1:0]    mag;
    logic [CW-1:0]          bit_cnt;

    logic [DW-1:0]          adj;
    logic [DW+IN_WIDTH:0]   shifted;
    logic                   neg_in;
    logic [IN_WIDTH-1:0]    mag_in;

    function automatic logic [DIGITS-1:0] blank_of(input logic [DW-1:0] d);
        logic [DIGITS-1:0] m;
        logic              z;
        m = '0;
        z = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            z    = z & (d[4*i +: 4] == 4'd0);
            m[i] = z;
        end
        return m;
    endfunction

    always_comb begin
        adj = digits;
        for (int i = 0; i < DIGITS; i++) begin
            if (digits[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = digits[4*i +: 4] + 4'd3;
        end
    end

    // Top bit is the carry out of the most significant digit; the rest is the shifted {digits, mag}.
    assign shifted = {adj, mag, 1'b0};

    assign neg_in = SIGNED_EN && signed_mode && bin_in[IN_WIDTH-1];
    assign mag_in = neg_in ? (~bin_in + IN_WIDTH'(1)) : bin_in;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign busy      = (state == CONVERT) || (state == HOLD);
    assign bcd_out   = digits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            digits     <= '0;
            mag        <= '0;
            bit_cnt    <= '0;
            sign       <= 1'b0;
            overflow   <= 1'b0;
            blank_mask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state      <= CONVERT;
                        digits     <= '0;
                        mag        <= mag_in;
                        sign       <= neg_in;
                        overflow   <= 1'b0;
                        bit_cnt    <= CW'(IN_WIDTH);
                        blank_mask <= blank_of('0);
                    end
                end
                CONVERT: begin
                    digits     <= shifted[DW+IN_WIDTH-1 -: DW];
                    mag        <= shifted[IN_WIDTH-1:0];
                    overflow   <= overflow | shifted[DW+IN_WIDTH];
                    blank_mask <= blank_of(shifted[DW+IN_WIDTH-1 -: DW]);
                    bit_cnt    <= bit_cnt - CW'(1);
                    if (bit_cnt == CW'(1))
                        state <= HOLD;
                end
                HOLD: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_stream.sv
// Randomized and directed bench for bin_to_bcd_stream; a 5-digit and a 4-digit
// instance run in lockstep against an arithmetic reference model.
module tb_bin_to_bcd_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        signed_mode = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] bin_in = '0;

    logic        in_ready, out_valid, sign, overflow, busy;
    logic [19:0] bcd_out;
    logic [4:0]  blank_mask;
    logic        in_ready4, out_valid4, sign4, overflow4, busy4;
    logic [15:0] bcd4;
    logic [3:0]  blank4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bin_to_bcd_stream #(.IN_WIDTH(16), .DIGITS(5), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .bin_in(bin_in), .signed_mode(signed_mode), .out_valid(out_valid),
        .out_ready(out_ready), .bcd_out(bcd_out), .sign(sign), .overflow(overflow),
        .blank_mask(blank_mask), .busy(busy)
    );

    bin_to_bcd_stream #(.IN_WIDTH(16), .DIGITS(4), .SIGNED_EN(1'b1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .bin_in(bin_in), .signed_mode(signed_mode), .out_valid(out_valid4),
        .out_ready(out_ready), .bcd_out(bcd4), .sign(sign4), .overflow(overflow4),
        .blank_mask(blank4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain decimal arithmetic on the integer magnitude.
    task automatic model(input logic [15:0] b, input logic sm, input int d,
                         output logic [31:0] bcd, output logic s, output logic ov,
                         output logic [31:0] mask);
        int mag, p, m;
        p = 1;
        repeat (d) p *= 10;
        s   = sm && b[15];
        mag = s ? (65536 - int'(b)) : int'(b);
        ov  = (mag >= p);
        m   = mag % p;
        bcd = '0;
        mask = '0;
        for (int i = 0; i < d; i++) begin
            bcd = bcd | (32'(m % 10) << (4 * i));
            m   = m / 10;
        end
        p = 10;
        for (int i = 1; i < d; i++) begin
            mask[i] = ((mag % (p * 10 ** (d - i))) / p == 0) || ((mag % (10 ** d)) / p == 0);
            p *= 10;
        end
    endtask

    task automatic check_outputs(input string ph, input logic [31:0] e5, input logic s5,
                                 input logic o5, input logic [31:0] m5, input logic [31:0] e4,
                                 input logic s4, input logic o4, input logic [31:0] m4);
        check({ph, "_bcd5"}, 32'(bcd_out), e5);
        check({ph, "_sign5"}, 32'(sign), 32'(s5));
        check({ph, "_ovf5"}, 32'(overflow), 32'(o5));
        check({ph, "_mask5"}, 32'(blank_mask), m5);
        check({ph, "_bcd4"}, 32'(bcd4), e4);
        check({ph, "_sign4"}, 32'(sign4), 32'(s4));
        check({ph, "_ovf4"}, 32'(overflow4), 32'(o4));
        check({ph, "_mask4"}, 32'(blank4), m4);
    endtask

    task automatic conv(input logic [15:0] b, input logic sm, input int hold);
        logic [31:0] e5, e4, m5, m4;
        logic        s5, o5, s4, o4;
        int          lat;
        model(b, sm, 5, e5, s5, o5, m5);
        model(b, sm, 4, e4, s4, o4, m4);
        lat = 0;
        while (!in_ready && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check("idle_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        bin_in = b; signed_mode = sm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; bin_in = 16'($urandom);
        check("conv_in_ready", 32'(in_ready), 32'd0);
        check("conv_busy", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", 32'(lat), 32'd16);
        check("lockstep_valid4", 32'(out_valid4), 32'd1);
        check_outputs("result", e5, s5, o5, m5, e4, s4, o4, m4);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom); bin_in = 16'($urandom); signed_mode = 1'($urandom);
            @(posedge clk); #1;
            check("hold_bcd5", 32'(bcd_out), e5);
            check("hold_sign5", 32'(sign), 32'(s5));
            check("hold_mask5", 32'(blank_mask), m5);
            check("hold_ovf4", 32'(overflow4), 32'(o4));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_busy", 32'(busy), 32'd0);
        check_outputs("kept", e5, s5, o5, m5, e4, s4, o4, m4);
    endtask

    initial begin
        #1;
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_mask", 32'(blank_mask), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        conv(16'hFFFF, 1'b0, 10);
        check("lit_ffff", 32'(bcd_out), 32'h65535);
        conv(16'h8000, 1'b1, 1);
        check("lit_8000s", 32'(bcd_out), 32'h32768);
        check("lit_8000s_sign", 32'(sign), 32'd1);
        conv(16'h8000, 1'b0, 0);
        check("lit_8000u_sign", 32'(sign), 32'd0);
        conv(16'hFFFF, 1'b1, 0);
        check("lit_m1_mask", 32'(blank_mask), 32'b11110);
        conv(16'd0, 1'b0, 0);
        check("lit_zero_mask", 32'(blank_mask), 32'b11110);
        conv(16'd12345, 1'b0, 0);
        check("lit_12345_d4", 32'(bcd4), 32'h2345);
        check("lit_12345_ovf4", 32'(overflow4), 32'd1);
        conv(16'd42, 1'b0, 0);
        check("lit_42_mask4", 32'(blank4), 32'b1100);
        check("lit_42_ovf4", 32'(overflow4), 32'd0);

        for (int n = 0; n < 40; n++)
            conv(16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        // Reset in the middle of a conversion.
        @(negedge clk);
        bin_in = 16'hABCD; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_bcd", 32'(bcd_out), 32'd0);
        check("midrst_sign", 32'(sign), 32'd0);
        check("midrst_ovf", 32'(overflow), 32'd0);
        check("midrst_mask", 32'(blank_mask), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        conv(16'd999, 1'b0, 2);
        check("lit_999", 32'(bcd_out), 32'h00999);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
